// File: rtl/fetch_mem_responder.sv
// ---------------------------------------------------------------------------
// fetch_mem_responder
//   Instruction-memory responder sitting at the far end of the fetch
//   interface. It latches the PC presented by the IF stage, waits a fixed
//   number of wait states, and then returns the addressed instruction word.
//   Until the current PC has been served it requests a stall (ORed into
//   StallF by the hazard unit). A branch redirect (flush) aborts the access
//   in flight. A loader port writes program images into the array.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pc_in        in   fetch address from the IF-stage PC register
//   flush        in   branch redirect; aborts the current access
//   instr        out  instruction word read for addr_q
//   instr_valid  out  instr corresponds to the current pc_in
//   stall_req    out  hold the PC (StallF source)
//   load_we      in   loader write enable
//   load_addr    in   loader word address
//   load_data    in   loader write data
//   misalign_err out  sticky: a latched PC had pc[1:0] != 0
// ---------------------------------------------------------------------------
module fetch_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           pc_in,
  input  logic                  flush,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic                  stall_req,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  misalign_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [31:0]           addr_q;
  logic [3:0]            cnt;
  logic [31:0]           mem [DEPTH];

  // Word index: byte-offset bits dropped, upper bits ignored so the
  // address wraps modulo the memory depth.
  logic [ADDR_WIDTH-1:0] idx;
  logic                  pc_match;
  logic                  load_hit;
  logic                  hit;

  // Per-edge actions decided alongside the next state.
  logic                  do_latch;    // capture pc_in, reload wait counter
  logic                  do_restart;  // loader overwrote our word: re-run access
  logic                  do_read;     // final wait edge: capture the word

  assign idx      = addr_q[ADDR_WIDTH+1:2];
  assign pc_match = (pc_in == addr_q);
  // A write to the word being fetched or already presented must not let the
  // old contents escape as valid, so the access is restarted.
  assign load_hit = load_we && (load_addr == idx) &&
                    ((state == ACCESS) || (state == DONE));
  assign hit      = (state == DONE) && pc_match;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next-state logic. flush overrides every other transition.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    do_latch   = 1'b0;
    do_restart = 1'b0;
    do_read    = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          do_latch  = 1'b1;
          state_nxt = ACCESS;
        end
        ACCESS: begin
          // Restart beats completion on the same edge: the read would see
          // the pre-write contents.
          if (load_hit) begin
            do_restart = 1'b1;
          end else if (cnt == 4'd0) begin
            do_read   = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE: begin
          // A new PC (including one that changed during ACCESS) is always
          // re-latched, so a stale word can never look like a hit.
          if (!pc_match) begin
            do_latch  = 1'b1;
            state_nxt = ACCESS;
          end else if (load_hit) begin
            do_restart = 1'b1;
            state_nxt  = ACCESS;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    instr_valid = hit;
    stall_req   = ~hit;
  end

  // -------------------------------------------------------------------------
  // Datapath: latched address, wait counter, returned word, sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= RESET_PC;
      cnt          <= 4'd0;
      instr        <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      if (flush)                       cnt <= 4'd0;
      else if (do_latch || do_restart) cnt <= WS;
      else if ((state == ACCESS) && (cnt != 4'd0)) cnt <= cnt - 4'd1;

      if (do_latch) begin
        addr_q <= pc_in;
        if (pc_in[1:0] != 2'b00) misalign_err <= 1'b1;
      end

      if (do_read) instr <= mem[idx];
    end
  end

  // Array is not reset; the loader may fill it while reset is held.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_fetch_mem_responder.sv
module tb_fetch_mem_responder;

  logic        clk;
  logic        reset_n, reset_n1;
  logic [31:0] pc_in, pc_in1;
  logic        flush;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] instr, instr1;
  logic        instr_valid, instr_valid1;
  logic        stall_req, stall_req1;
  logic        misalign_err, misalign_err1;

  int total = 0;
  int bad   = 0;

  fetch_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall_req(stall_req),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .misalign_err(misalign_err)
  );

  fetch_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .reset_n(reset_n1), .pc_in(pc_in1), .flush(flush),
    .instr(instr1), .instr_valid(instr_valid1), .stall_req(stall_req1),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .misalign_err(misalign_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b exp=1", stall_req); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
    load_word(10'd0, 32'h11111111);
    load_word(10'd1, 32'h22222222);
    load_word(10'd2, 32'h33333333);
    load_word(10'd3, 32'h44444444);
  endtask

  task automatic test_first_fetch();
    @(negedge clk); pc_in = 32'h0; reset_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      total++; if (stall_req !== 1'b1 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL first_wait[%0d] stall=%b valid=%b exp stall=1 valid=0", i, stall_req, instr_valid); end
    end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b1 || stall_req !== 1'b0 || instr !== 32'h11111111) begin
      bad++; $display("FAIL first_data valid=%b stall=%b instr=%h exp 1/0/11111111", instr_valid, stall_req, instr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [2];
    exp_w[0] = 32'h22222222; exp_w[1] = 32'h33333333;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); pc_in = 32'(4 * (k + 1)); #1;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        total++; if (instr_valid !== 1'b0 || stall_req !== 1'b1) begin
          bad++; $display("FAIL seq_wait[%0d][%0d] valid=%b stall=%b exp 0/1", k, i, instr_valid, stall_req); end
      end
      @(negedge clk); #1;
      total++; if (instr_valid !== 1'b1 || stall_req !== 1'b0 || instr !== exp_w[k]) begin
        bad++; $display("FAIL seq_data[%0d] valid=%b stall=%b instr=%h exp 1/0/%h", k, instr_valid, stall_req, instr, exp_w[k]); end
    end
  endtask

  task automatic test_flush();
    @(negedge clk); pc_in = 32'h4; #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL flush_pre0 valid=%b exp=0", instr_valid); end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL flush_pre1 valid=%b exp=0", instr_valid); end
    @(negedge clk); flush = 1'b1; pc_in = 32'hC; #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL flush_pre2 valid=%b exp=0", instr_valid); end
    @(negedge clk); flush = 1'b0; #1;
    total++; if (instr_valid !== 1'b0 || instr !== 32'h33333333) begin
      bad++; $display("FAIL flush_abort valid=%b instr=%h exp 0/33333333", instr_valid, instr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL flush_wait[%0d] valid=%b exp=0", i, instr_valid); end
    end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h44444444) begin
      bad++; $display("FAIL flush_data valid=%b instr=%h exp 1/44444444", instr_valid, instr); end
  endtask

  task automatic test_loader();
    @(negedge clk); pc_in = 32'h8; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL load_setup[%0d] valid=%b exp=0", i, instr_valid); end
    end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h33333333) begin
      bad++; $display("FAIL load_setup_data valid=%b instr=%h exp 1/33333333", instr_valid, instr); end
    @(negedge clk); load_we = 1'b1; load_addr = 10'd2; load_data = 32'hDEADBEEF; #1;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL load_before valid=%b exp=1", instr_valid); end
    @(negedge clk); load_we = 1'b0; #1;
    total++; if (instr_valid !== 1'b0 || stall_req !== 1'b1) begin
      bad++; $display("FAIL load_drop valid=%b stall=%b exp 0/1", instr_valid, stall_req); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL load_wait[%0d] valid=%b exp=0", i, instr_valid); end
    end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'hDEADBEEF) begin
      bad++; $display("FAIL load_data valid=%b instr=%h exp 1/deadbeef", instr_valid, instr); end
  endtask

  // Loader write to the fetched word on the very edge the access would finish.
  task automatic test_load_final_edge();
    @(negedge clk); pc_in = 32'hC; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL lfe_pre[%0d] valid=%b exp=0", i, instr_valid); end
    end
    @(negedge clk); load_we = 1'b1; load_addr = 10'd3; load_data = 32'h55555555; #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL lfe_cnt0 valid=%b exp=0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load_we = 1'b0; #1;
      total++; if (instr_valid !== 1'b0) begin
        bad++; $display("FAIL lfe_restart[%0d] valid=%b instr=%h exp valid=0", i, instr_valid, instr); end
    end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h55555555) begin
      bad++; $display("FAIL lfe_data valid=%b instr=%h exp 1/55555555", instr_valid, instr); end
  endtask

  task automatic test_misalign_wrap();
    @(negedge clk); #1;
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_before got=%b exp=0", misalign_err); end
    pc_in = 32'h00001002; #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_set got=%b exp=1", misalign_err); end
      end
    end
    @(negedge clk); #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h11111111) begin
      bad++; $display("FAIL wrap_data valid=%b instr=%h exp 1/11111111", instr_valid, instr); end
    @(negedge clk); pc_in = 32'h0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h11111111 || misalign_err !== 1'b1) begin
      bad++; $display("FAIL mis_sticky valid=%b instr=%h mis=%b exp 1/11111111/1", instr_valid, instr, misalign_err); end
    @(negedge clk); reset_n = 1'b0; #1;
    total++; if (misalign_err !== 1'b0 || instr !== 32'd0 || stall_req !== 1'b1 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL mis_reset mis=%b instr=%h stall=%b valid=%b exp 0/00000000/1/0", misalign_err, instr, stall_req, instr_valid); end
  endtask

  task automatic test_zero_wait();
    @(negedge clk); pc_in1 = 32'h0; reset_n1 = 1'b1; #1;
    total++; if (instr_valid1 !== 1'b0) begin bad++; $display("FAIL ws0_idle valid=%b exp=0", instr_valid1); end
    @(negedge clk); #1;
    total++; if (instr_valid1 !== 1'b0) begin bad++; $display("FAIL ws0_acc valid=%b exp=0", instr_valid1); end
    @(negedge clk); #1;
    total++; if (instr_valid1 !== 1'b1 || instr1 !== 32'h11111111) begin
      bad++; $display("FAIL ws0_first valid=%b instr=%h exp 1/11111111", instr_valid1, instr1); end
    @(negedge clk); pc_in1 = 32'h4; #1;
    total++; if (instr_valid1 !== 1'b0) begin bad++; $display("FAIL ws0_step0 valid=%b exp=0", instr_valid1); end
    @(negedge clk); #1;
    total++; if (instr_valid1 !== 1'b0) begin bad++; $display("FAIL ws0_step1 valid=%b exp=0", instr_valid1); end
    @(negedge clk); #1;
    total++; if (instr_valid1 !== 1'b1 || instr1 !== 32'h22222222) begin
      bad++; $display("FAIL ws0_step2 valid=%b instr=%h exp 1/22222222", instr_valid1, instr1); end
    @(negedge clk); pc_in1 = 32'h8;
    @(negedge clk); #1;
    // Now in ACCESS; reset must take effect without a clock edge.
    reset_n1 = 1'b0; #1;
    total++; if (instr1 !== 32'd0 || stall_req1 !== 1'b1 || instr_valid1 !== 1'b0) begin
      bad++; $display("FAIL ws0_async instr=%h stall=%b valid=%b exp 00000000/1/0", instr1, stall_req1, instr_valid1); end
    @(negedge clk); reset_n1 = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    total++; if (instr_valid1 !== 1'b1 || instr1 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ws0_restart valid=%b instr=%h exp 1/deadbeef", instr_valid1, instr1); end
  endtask

  initial begin
    reset_n = 1'b0; reset_n1 = 1'b0;
    pc_in = 32'h0; pc_in1 = 32'h0;
    flush = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_flush();
    test_loader();
    test_load_final_edge();
    test_misalign_wrap();
    test_zero_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
